// File: rtl/uart_rx.sv
// UART receiver: two-flop line synchroniser, mid-bit sampling FSM,
// one-cycle byte strobe and framing-error pulse.
module uart_rx #(
  parameter int BAUD_RATE      = 115_200,
  parameter int CLOCK_SPEED    = 50_000_000,
  parameter int BAUD_WIDTH     = CLOCK_SPEED / BAUD_RATE,
  parameter int HALF_WIDTH     = BAUD_WIDTH / 2,
  parameter int INVERT_PAYLOAD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_WIDTH);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_WIDTH - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_WIDTH - 1);
  localparam logic INV = (INVERT_PAYLOAD != 0);

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    START     = 5'b00010,
    DATA      = 5'b00100,
    STOP      = 5'b01000,
    WAIT_IDLE = 5'b10000
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          rx_s1;
  logic          rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= cnt + CW'(1);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s2) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            if (rx_s2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shreg[idx] <= rx_s2 ^ INV;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s2) begin
              data     <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // a held-low line (break) reports only once, then waits here
          cnt <= '0;
          if (rx_s2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, glitch, break,
// mid-frame reset and bit-rate tolerance.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   vcyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   extra = 0;
  int   t_start = 0;
  bit   lat_on = 0;
  bit   prev_pulse = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every output pulse
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst && (rx_valid || frame_err)) begin
      checks++;
      if (rx_valid && frame_err) begin
        errors++;
        $display("FAIL excl: rx_valid and frame_err both high");
      end else if (prev_pulse) begin
        errors++;
        $display("FAIL consec: pulse on two consecutive cycles");
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        extra++;
        $display("FAIL unexpected: err=%0b data=%0h", frame_err, data);
      end else begin
        e = sb.pop_front();
        if (e.err != frame_err || e.d != data) begin
          errors++;
          $display("FAIL sb: got err=%0b data=%0h expected err=%0b data=%0h",
                   frame_err, data, e.err, e.d);
        end
      end
      if (rx_valid) begin
        vcyc.push_back(cyc);
        if (lat_on) begin
          lat_on = 0;
          lat = cyc - t_start;
          checks++;
          if (lat < 4126 || lat > 4128) begin
            errors++;
            $display("FAIL latency: got %0d expected 4127+-1", lat);
          end
        end
      end
    end
    prev_pulse = !rst && (rx_valid || frame_err);
  end

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int per, input logic stp);
    line(1'b0, per);
    for (int i = 0; i < 8; i++) line(~b[i], per);
    line(stp, per);
  endtask

  task automatic push(input logic err, input logic [7:0] d);
    exp_t e;
    e.err = err;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, sb.size(), 0);
  endtask

  initial begin
    rst = 1;
    rx  = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    line(1'b1, 20);

    // single byte with latency window
    push(1'b0, 8'hA5);
    t_start = cyc;
    lat_on  = 1;
    send(8'hA5, 434, 1'b1);
    drain("single_drain");
    chk("single_data", data, 8'hA5);
    line(1'b1, 50);

    // back-to-back, no idle gap
    vcyc.delete();
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    push(1'b0, 8'h3C);
    send(8'h00, 434, 1'b1);
    send(8'hFF, 434, 1'b1);
    send(8'h3C, 434, 1'b1);
    drain("b2b_drain");
    chk("b2b_count", vcyc.size(), 3);
    if (vcyc.size() == 3) begin
      chk("b2b_gap1", (vcyc[1] - vcyc[0] >= 4338 &&
                       vcyc[1] - vcyc[0] <= 4342), 1);
      chk("b2b_gap2", (vcyc[2] - vcyc[1] >= 4338 &&
                       vcyc[2] - vcyc[1] <= 4342), 1);
    end
    line(1'b1, 50);

    // glitch: false start returns to idle silently
    line(1'b0, 100);
    line(1'b1, 50);
    chk("glitch_busy_hi", busy, 1);
    line(1'b1, 180);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_data", data, 8'h3C);

    // framing error followed by a long break
    push(1'b1, 8'h3C);
    send(8'h55, 434, 1'b0);
    line(1'b0, 5000);
    drain("ferr_drain");
    chk("ferr_busy_hi", busy, 1);
    chk("ferr_data", data, 8'h3C);
    line(1'b1, 10);
    chk("ferr_busy_lo", busy, 0);
    line(1'b1, 50);

    // reset during payload bit 4 of 8'hC3, transmitter aborts
    line(1'b0, 434);
    for (int i = 0; i < 4; i++) line(~(8'hC3 >> i) & 1'b1, 434);
    line(1'b1, 200);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("mrst_data", data, 8'h00);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_busy", busy, 0);
    line(1'b1, 1000);
    chk("mrst_no_pulse", extra, 0);
    push(1'b0, 8'h81);
    send(8'h81, 434, 1'b1);
    drain("mrst_next");
    chk("mrst_next_data", data, 8'h81);
    line(1'b1, 50);

    // bit-rate tolerance
    push(1'b0, 8'h96);
    send(8'h96, 425, 1'b1);
    drain("fast_drain");
    chk("fast_data", data, 8'h96);
    line(1'b1, 100);
    data_clear_check();
    push(1'b0, 8'h96);
    send(8'h96, 443, 1'b1);
    drain("slow_drain");
    chk("slow_data", data, 8'h96);
    line(1'b1, 100);

    chk("sb_empty", sb.size(), 0);
    chk("extra_total", extra, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic data_clear_check();
    chk("idle_between", busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
